// File: rtl/serial_rx_7bit_pkg.sv
// Shared constants for the 7-bit serial receiver:
// FSM encodings, frame width and default bit period.
package serial_rx_7bit_pkg;

   localparam int DATA_W           = 7;
   localparam int CLKS_PER_BIT_DEF = 16;

   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] START     = 3'd1;
   localparam logic [2:0] DATA      = 3'd2;
   localparam logic [2:0] PARITY    = 3'd3;
   localparam logic [2:0] STOP      = 3'd4;
   localparam logic [2:0] WAIT_IDLE = 3'd5;

endpackage

// File: rtl/rx_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input,
// reset to a selectable idle level.
module rx_sync_2ff #(
   parameter bit RST_VAL = 1'b1
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         meta_q <= RST_VAL;
         sync_q <= RST_VAL;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/serial_rx_7bit.sv
// Serial receiver: start bit, 7 data bits LSB-first,
// optional even parity, stop bit; one-cycle result pulses.
module serial_rx_7bit
   import serial_rx_7bit_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
   parameter bit PARITY_EN    = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              rx_in,
   output logic [DATA_W-1:0] data_out,
   output logic              data_valid,
   output logic              parity_err,
   output logic              frame_err,
   output logic              busy
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] CNT_MID = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [2:0]    IDX_LAST = 3'(DATA_W - 1);

   logic              rxs;
   logic [2:0]        state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [2:0]        idx_q, idx_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic              par_q, par_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              dv_q, dv_d;
   logic              pe_q, pe_d;
   logic              fe_q, fe_d;

   rx_sync_2ff #(
      .RST_VAL(1'b1)
   ) u_sync (
      .clk_i (clk),
      .rst_ni(reset),
      .d_i   (rx_in),
      .q_o   (rxs)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 1'b1;
      idx_d   = idx_q;
      shift_d = shift_q;
      par_d   = par_q;
      data_d  = data_q;
      dv_d    = 1'b0;
      pe_d    = 1'b0;
      fe_d    = 1'b0;
      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            idx_d = '0;
            if (!rxs) state_d = START;
         end
         START: begin
            if (cnt_q == CNT_MID) begin
               cnt_d   = '0;
               state_d = rxs ? IDLE : DATA;
            end
         end
         DATA: begin
            if (cnt_q == CNT_MAX) begin
               cnt_d   = '0;
               shift_d = {rxs, shift_q[DATA_W-1:1]};
               idx_d   = idx_q + 3'd1;
               if (idx_q == IDX_LAST) begin
                  idx_d   = '0;
                  state_d = PARITY_EN ? PARITY : STOP;
               end
            end
         end
         PARITY: begin
            if (cnt_q == CNT_MAX) begin
               cnt_d   = '0;
               par_d   = rxs;
               state_d = STOP;
            end
         end
         STOP: begin
            if (cnt_q == CNT_MAX) begin
               cnt_d = '0;
               if (!rxs) begin
                  fe_d    = 1'b1;
                  state_d = WAIT_IDLE;
               end else if (PARITY_EN && ((^shift_q) ^ par_q)) begin
                  pe_d    = 1'b1;
                  state_d = IDLE;
               end else begin
                  dv_d    = 1'b1;
                  data_d  = shift_q;
                  state_d = IDLE;
               end
            end
         end
         WAIT_IDLE: begin
            // A held-low line (break) must not look like a new start bit.
            cnt_d = '0;
            if (rxs) state_d = IDLE;
         end
         default: begin
            cnt_d   = '0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         par_q   <= 1'b0;
         data_q  <= '0;
         dv_q    <= 1'b0;
         pe_q    <= 1'b0;
         fe_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         par_q   <= par_d;
         data_q  <= data_d;
         dv_q    <= dv_d;
         pe_q    <= pe_d;
         fe_q    <= fe_d;
      end
   end

   assign data_out   = data_q;
   assign data_valid = dv_q;
   assign parity_err = pe_q;
   assign frame_err  = fe_q;
   assign busy       = (state_q != IDLE);

endmodule
